fixedpt_pow_seq: RTL and testbench

- Sequential, parametrised successor to the combinational Q16.16 power unit in the insurance benchmark.
- Computes out = p^b for an unsigned fixed-point base p (FRAC_W fraction bits) and a signed integer exponent b.
- Uses iterative square-and-multiply, one exponent bit per cycle, and an iterative restoring divider for the reciprocal when b is negative.
- Adds a valid/ready handshake, sticky overflow and divide-by-zero flags, and width/exponent generality; one operation in flight.

---
 rtl/fixedpt_pow_seq.sv | 215 +++++++++++++++++++++
 tb/tb_fixedpt_pow_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fixedpt_pow_seq.sv
// fixedpt_pow_seq -- sequential fixed-point power unit, out = p^b.
//
// p is unsigned fixed point with FRAC_W fraction bits, b is a signed
// EXP_W-bit integer exponent. |b| is applied by square-and-multiply, one
// exponent bit per cycle (EXP_W cycles). A negative exponent adds a
// restoring division of 1<<(2*FRAC_W) by that result (2*FRAC_W+1 cycles).
// Latency does not depend on operand values. One operation in flight.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE (and never during reset).
// out_valid stays high, with out/ovf/dz stable, until out_ready is seen.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid
//   in_ready   idle, request can be accepted
//   p          base, unsigned fixed point (W bits)
//   b          exponent, two's complement (EXP_W bits)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out        result (W bits)
//   ovf        a committed product lost integer bits
//   dz         negative exponent with a zero pre-reciprocal result
//   dbg_state  current FSM state (IDLE=0, POW=1, DIV=2, DONE=3)
module fixedpt_pow_seq #(
    parameter int W      = 32,
    parameter int FRAC_W = 16,
    parameter int EXP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     p,
    input  logic [EXP_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out,
    output logic             ovf,
    output logic             dz,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POW  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIV_CYC = 2 * FRAC_W + 1;
    localparam int CNT_MAX = (DIV_CYC > EXP_W) ? DIV_CYC : EXP_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] POW_LAST = CNT_W'(EXP_W - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYC - 1);
    localparam logic [W-1:0]     ONE      = W'(1) << FRAC_W;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]     acc;
    logic [W-1:0]     sq;
    logic [EXP_W-1:0] mag_sh;   // |b|, shifted right each POW cycle
    logic             neg;
    logic [CNT_W-1:0] cnt;      // POW step, then DIV quotient-bit counter
    logic [W-1:0]     rem;
    logic [W-1:0]     quo;

    logic             accept;
    logic             pow_last;
    logic             div_last;
    logic [2*W-1:0]   prod_a;
    logic [2*W-1:0]   prod_s;
    logic             cur_bit;
    logic             more_bits;
    logic [W-1:0]     acc_step;
    logic             ovf_step;
    logic [W:0]       div_rem_sh;
    logic [W:0]       div_diff;
    logic             div_ge;
    logic [W-1:0]     rem_nxt;
    logic [W-1:0]     quo_nxt;
    logic             unused_bits;

    // ---------------- datapath combinational terms ----------------
    assign accept    = in_valid && in_ready;
    assign pow_last  = (cnt == POW_LAST);
    assign div_last  = (cnt == DIV_LAST);

    assign prod_a    = (2*W)'(acc) * (2*W)'(sq);
    assign prod_s    = (2*W)'(sq) * (2*W)'(sq);

    // mag_sh[0] is the exponent bit of the current step; anything above it
    // is still to be multiplied in, which is when a lost square matters.
    assign cur_bit   = mag_sh[0];
    assign more_bits = |mag_sh[EXP_W-1:1];

    assign acc_step  = cur_bit ? prod_a[W+FRAC_W-1:FRAC_W] : acc;
    assign ovf_step  = (cur_bit && (|prod_a[2*W-1:W+FRAC_W]))
                     || ((|prod_s[2*W-1:W+FRAC_W]) && more_bits);

    // Dividend 1<<(2*FRAC_W) has a single 1 at its MSB, which is the bit
    // shifted in on the first DIV cycle; all later bits are zero.
    assign div_rem_sh = {rem, (cnt == '0)};
    assign div_diff   = div_rem_sh - {1'b0, acc};
    assign div_ge     = (div_rem_sh >= {1'b0, acc});
    assign rem_nxt    = div_ge ? div_diff[W-1:0] : div_rem_sh[W-1:0];
    // Only the low W quotient bits are kept; higher bits fall off the top.
    assign quo_nxt    = {quo[W-2:0], div_ge};

    assign unused_bits = ^{prod_a[FRAC_W-1:0], prod_s[FRAC_W-1:0],
                           div_diff[W], quo[W-1]};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (accept) begin
                    state_nxt = POW;
                end
            end
            POW: begin
                if (pow_last) begin
                    state_nxt = neg ? DIV : DONE;
                end
            end
            DIV: begin
                if (div_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dbg_state = state;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= '0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
            acc    <= '0;
            sq     <= '0;
            mag_sh <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Two's-complement negate wraps, so the most
                        // negative b yields 1<<(EXP_W-1) as intended.
                        mag_sh <= b[EXP_W-1] ? -b : b;
                        neg    <= b[EXP_W-1];
                        acc    <= ONE;
                        sq     <= p;
                        cnt    <= '0;
                        ovf    <= 1'b0;
                        dz     <= 1'b0;
                    end
                end
                POW: begin
                    acc    <= acc_step;
                    sq     <= prod_s[W+FRAC_W-1:FRAC_W];
                    mag_sh <= mag_sh >> 1;
                    ovf    <= ovf | ovf_step;
                    cnt    <= cnt + CNT_W'(1);
                    if (pow_last) begin
                        cnt <= '0;
                        rem <= '0;
                        quo <= '0;
                        if (!neg) begin
                            out <= acc_step;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (div_last) begin
                        dz  <= (acc == '0);
                        out <= (acc == '0) ? '1 : quo_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixedpt_pow_seq.sv
// Directed bench for fixedpt_pow_seq (W=32, FRAC_W=16, EXP_W=8).
// Expected values are hand-computed fixed-point powers/reciprocals.
module tb_fixedpt_pow_seq;

    localparam int W      = 32;
    localparam int FRAC_W = 16;
    localparam int EXP_W  = 8;
    localparam int MAX_WAIT = 200;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     p;
    logic [EXP_W-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out;
    logic             ovf;
    logic             dz;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    fixedpt_pow_seq #(.W(W), .FRAC_W(FRAC_W), .EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf),
        .dz        (dz),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Present one request and let the accepting edge pass.
    task automatic send(input string tag, input logic [W-1:0] tp,
                        input logic [EXP_W-1:0] tbv);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        p        = tp;
        b        = tbv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid rises.
    task automatic wait_result(input string tag, input int e_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
    endtask

    // Scoreboard: pop the expected result and compare out/ovf/dz.
    task automatic score(input string tag, input logic e_ovf, input logic e_dz);
        logic [W-1:0] e_out;
        check({tag, " sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        e_out = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, " out"}, out, e_out);
        check({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
        check({tag, " dz"},  32'(dz),  32'(e_dz));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] tp,
                          input logic [EXP_W-1:0] tbv, input logic [W-1:0] e_out,
                          input logic e_ovf, input logic e_dz, input int e_lat);
        exp_q.push_back(e_out);
        send(tag, tp, tbv);
        wait_result(tag, e_lat);
        score(tag, e_ovf, e_dz);
        tick();
        check({tag, " back_idle"}, 32'(in_ready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p         = '0;
        b         = '0;
        repeat (3) tick();

        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out",       out,            32'd0);
        check("rst ovf",       32'(ovf),       32'd0);
        check("rst dz",        32'(dz),        32'd0);
        check("rst in_ready",  32'(in_ready),  32'd0);
        check("rst state",     32'(dbg_state), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst in_ready", 32'(in_ready), 32'd1);

        // 2.0^3 = 8.0
        run_op("pow2_3",    32'h0002_0000, 8'd3,   32'h0008_0000, 1'b0, 1'b0, 8);
        // 2.0^-2 = 0.25
        run_op("pow2_m2",   32'h0002_0000, 8'hFE,  32'h0000_4000, 1'b0, 1'b0, 41);
        // 0^-1: zero before reciprocal
        run_op("zero_m1",   32'h0000_0000, 8'hFF,  32'hFFFF_FFFF, 1'b0, 1'b1, 41);
        // 1.0^-128: most negative exponent
        run_op("one_m128",  32'h0001_0000, 8'h80,  32'h0001_0000, 1'b0, 1'b0, 41);
        // any^0 = 1.0, squares overflow but nothing is committed
        run_op("any_0",     32'h1234_5678, 8'd0,   32'h0001_0000, 1'b0, 1'b0, 8);
        // 256.0^2 loses integer bits
        run_op("big_2",     32'h0100_0000, 8'd2,   32'h0000_0000, 1'b1, 1'b0, 8);
        // following request clears ovf
        run_op("three_1",   32'h0003_0000, 8'd1,   32'h0003_0000, 1'b0, 1'b0, 8);
        // 0^5 = 0 without ovf
        run_op("zero_5",    32'h0000_0000, 8'd5,   32'h0000_0000, 1'b0, 1'b0, 8);
        // 1.5^2 = 2.25
        run_op("p15_2",     32'h0001_8000, 8'd2,   32'h0002_4000, 1'b0, 1'b0, 8);

        // Backpressure: hold the dz result while in_valid pulses arrive.
        out_ready = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        send("bp", 32'h0000_0000, 8'hFF);
        wait_result("bp", 41);
        score("bp", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            p        = 32'h0003_0000;
            b        = 8'd1;
            in_valid = 1'b1;
            tick();
            check("bp hold out",       out,            32'hFFFF_FFFF);
            check("bp hold dz",        32'(dz),        32'd1);
            check("bp hold ovf",       32'(ovf),       32'd0);
            check("bp hold in_ready",  32'(in_ready),  32'd0);
            check("bp hold out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready",  32'(in_ready),  32'd1);
        // A swallowed pulse would show up as a wrong result or latency here.
        run_op("after_bp",  32'h0003_0000, 8'd2,   32'h0009_0000, 1'b0, 1'b0, 8);

        // Reset in the middle of DIV abandons the operation.
        send("rst_mid", 32'h0002_0000, 8'hFE);
        repeat (15) tick();
        check("rst_mid in_div", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        tick();
        check("rst_mid out_valid", 32'(out_valid), 32'd0);
        check("rst_mid out",       out,            32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid in_ready",  32'(in_ready),  32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check("rst_mid no_stale", 32'(saw_valid), 32'd0);
        // 0.5^-1 = 2.0 with nominal latency
        run_op("after_rst", 32'h0000_8000, 8'hFF,  32'h0002_0000, 1'b0, 1'b0, 41);

        check("sb drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
